norm_seq_divider: RTL and testbench

//  Parametrised multi-cycle fixed-point divider, the successor to the fixed 36-bit normalising divider.

---
 rtl/norm_seq_divider.sv | 266 ++++++++++++++++++++++++++
 tb/tb_norm_seq_divider.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_seq_divider.sv
// norm_seq_divider
//   Multi-cycle fixed-point divider for the ratio/normalisation path.
//   quotient  = (dividend << FRAC) / divisor
//   remainder = (dividend << FRAC) % divisor
//   Operands are unsigned or two's-complement, chosen per operation.
//   Leading-one detection on both magnitudes skips the iterations that
//   could only produce leading zero quotient bits.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   in_valid     operands valid
//   in_ready     operands accepted (IDLE only)
//   dividend     DW-bit dividend, sampled on input handshake
//   divisor      VW-bit divisor, sampled on input handshake
//   signed_mode  1 = two's-complement operands/results
//   out_valid    result valid (DONE)
//   out_ready    consumer accepts result
//   quotient     W-bit quotient, W = DW+FRAC, stable while out_valid
//   remainder    VW-bit remainder, stable while out_valid
//   div_by_zero  result produced with a zero divisor
//   ovf          signed quotient saturated
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for operands, in_ready=1
// S_NORM | align divisor to dividend msb, resolve trivial cases
// S_ITER | one restoring subtract/shift per cycle, count down to 0
// S_DONE | signed result presented, waiting for out_ready

module norm_seq_divider #(
   parameter int DW   = 22,
   parameter int VW   = 15,
   parameter int FRAC = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DW-1:0]        dividend,
   input  logic [VW-1:0]        divisor,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW+FRAC-1:0]   quotient,
   output logic [VW-1:0]        remainder,
   output logic                 div_by_zero,
   output logic                 ovf
);

   localparam int W  = DW + FRAC;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_NORM = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // working registers
   logic [W-1:0]   r_rem;
   logic [W-1:0]   r_dsh;
   logic [W-2:0]   r_q;
   logic [VW-1:0]  r_d;
   logic [CW-1:0]  r_cnt;
   logic           r_neg_q;
   logic           r_neg_r;
   logic           r_signed;

   // result registers
   logic [W-1:0]   r_quotient;
   logic [VW-1:0]  r_remainder;
   logic           r_dbz;
   logic           r_ovf;

   // FSM strobes
   logic           w_accept;
   logic           w_go_iter;
   logic           w_step;
   logic           w_load_dbz;
   logic           w_load_res;

   // operand magnitudes at the input handshake
   logic           w_a_neg;
   logic           w_b_neg;
   logic [DW-1:0]  w_a_mag;
   logic [VW-1:0]  w_b_mag;
   logic [W-1:0]   w_n;

   // normalisation
   logic [W-1:0]   w_d_ext;
   logic [CW-1:0]  w_msb_n;
   logic [CW-1:0]  w_msb_d;
   logic [CW-1:0]  w_shift;
   logic           w_d_zero;
   logic           w_n_lt_d;

   // iteration
   logic           w_ge;
   logic [W-1:0]   w_rem_next;
   logic [W-1:0]   w_q_next;

   // sign application
   logic [W-1:0]   w_res_q;
   logic [VW-1:0]  w_res_r;
   logic           w_sat;
   logic [W-1:0]   w_q_out;
   logic [VW-1:0]  w_r_out;
   logic [W-1:0]   w_q_dbz;

   function automatic logic [CW-1:0] msb_pos(input logic [W-1:0] x);
      logic [CW-1:0] p;
      p = '0;
      for (int i = 0; i < W; i++) begin
         if (x[i]) p = CW'(i);
      end
      return p;
   endfunction

   assign w_a_neg = signed_mode & dividend[DW-1];
   assign w_b_neg = signed_mode & divisor[VW-1];
   assign w_a_mag = w_a_neg ? -dividend : dividend;
   assign w_b_mag = w_b_neg ? -divisor : divisor;
   assign w_n     = {w_a_mag, {FRAC{1'b0}}};

   assign w_d_ext  = {{(W-VW){1'b0}}, r_d};
   assign w_msb_n  = msb_pos(r_rem);
   assign w_msb_d  = msb_pos(w_d_ext);
   // only used when N >= D, so the difference is never negative
   assign w_shift  = w_msb_n - w_msb_d;
   assign w_d_zero = (r_d == '0);
   // Early exit whenever N < D: the quotient is zero and the remainder is N.
   // This covers N==0, a negative shift, and the equal-msb case where the
   // single iteration could only produce a zero bit.
   assign w_n_lt_d = (r_rem < w_d_ext);

   assign w_ge       = (r_rem >= r_dsh);
   assign w_rem_next = w_ge ? (r_rem - r_dsh) : r_rem;
   assign w_q_next   = {r_q, w_ge};

   // result source: last iteration, or the early-exit case from NORM
   assign w_res_q = w_step ? w_q_next : '0;
   assign w_res_r = w_step ? w_rem_next[VW-1:0] : r_rem[VW-1:0];

   // only a positive signed result can exceed the largest positive value;
   // the most negative quotient magnitude (2^(W-1)) negates exactly
   assign w_sat   = r_signed & ~r_neg_q & w_res_q[W-1];
   assign w_q_out = w_sat   ? {1'b0, {(W-1){1'b1}}}
                  : r_neg_q ? -w_res_q
                  :           w_res_q;
   assign w_r_out = r_neg_r ? -w_res_r : w_res_r;

   assign w_q_dbz = !r_signed ? {W{1'b1}}
                  : r_neg_r   ? {1'b1, {(W-1){1'b0}}}
                  :             {1'b0, {(W-1){1'b1}}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      w_go_iter   = 1'b0;
      w_step      = 1'b0;
      w_load_dbz  = 1'b0;
      w_load_res  = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_NORM;
            end
         end
         S_NORM: begin
            if (w_d_zero) begin
               w_load_dbz  = 1'b1;
               w_state_nxt = S_DONE;
            end else if (w_n_lt_d) begin
               w_load_res  = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_go_iter   = 1'b1;
               w_state_nxt = S_ITER;
            end
         end
         S_ITER: begin
            w_step = 1'b1;
            if (r_cnt == '0) begin
               w_load_res  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rem       <= '0;
         r_dsh       <= '0;
         r_q         <= '0;
         r_d         <= '0;
         r_cnt       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_signed    <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rem    <= w_n;
            r_d      <= w_b_mag;
            r_q      <= '0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_signed <= signed_mode;
         end
         if (w_go_iter) begin
            r_dsh <= w_d_ext << w_shift;
            r_cnt <= w_shift;
         end
         if (w_step) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next[W-2:0];
            r_dsh <= r_dsh >> 1;
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_load_dbz) begin
            r_quotient  <= w_q_dbz;
            r_remainder <= '0;
            r_dbz       <= 1'b1;
            r_ovf       <= 1'b0;
         end
         if (w_load_res) begin
            r_quotient  <= w_q_out;
            r_remainder <= w_r_out;
            r_dbz       <= 1'b0;
            r_ovf       <= w_sat;
         end
      end
   end

   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;
   assign ovf         = r_ovf;

endmodule

// File: tb/tb_norm_seq_divider.sv
// tb_norm_seq_divider
//   Directed and randomised checks of norm_seq_divider (DW=22, VW=15,
//   FRAC=14). Random results come from a longint arithmetic reference.

module tb_norm_seq_divider;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [21:0] dividend;
   logic [14:0] divisor;
   logic        signed_mode;
   logic        out_valid;
   logic        out_ready;
   logic [35:0] quotient;
   logic [14:0] remainder;
   logic        div_by_zero;
   logic        ovf;

   int n_cmp;
   int n_bad;

   localparam longint MAXS = 64'sd34359738367;

   norm_seq_divider #(.DW(22), .VW(15), .FRAC(14)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .ovf         (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int msb64(input longint x);
      int p;
      p = 0;
      for (int i = 0; i < 63; i++) begin
         if (x >= (longint'(1) << i)) p = i;
      end
      return p;
   endfunction

   task automatic model(input logic [21:0] a, input logic [14:0] b, input logic sm,
                        output logic [35:0] eq, output logic [14:0] er,
                        output logic edbz, output logic eovf, output int elat);
      longint sa, sb, ma, mb, n, qm, rm, qs, rs;
      sa = sm ? longint'($signed(a)) : longint'(a);
      sb = sm ? longint'($signed(b)) : longint'(b);
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      n  = ma * 16384;
      if (mb == 0) begin
         edbz = 1'b1;
         eovf = 1'b0;
         er   = '0;
         elat = 1;
         if (!sm)        eq = '1;
         else if (sa < 0) eq = 36'h800000000;
         else            eq = 36'h7FFFFFFFF;
      end else begin
         edbz = 1'b0;
         qm   = n / mb;
         rm   = n % mb;
         qs   = ((sa < 0) != (sb < 0)) ? -qm : qm;
         rs   = (sa < 0) ? -rm : rm;
         eovf = sm && (qs > MAXS);
         if (eovf) qs = MAXS;
         eq   = qs[35:0];
         er   = rs[14:0];
         elat = (n < mb) ? 1 : msb64(n) - msb64(mb) + 2;
      end
   endtask

   // accept happens on the edge this task waits for (edge 0)
   task automatic start_op(input logic [21:0] a, input logic [14:0] b, input logic sm);
      @(negedge clk);
      dividend    = a;
      divisor     = b;
      signed_mode = sm;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      dividend    = 22'($urandom);
      divisor     = 15'($urandom);
      signed_mode = 1'($urandom);
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++; if (quotient !== 36'd0) begin n_bad++; $display("FAIL reset_quotient got %h want 0", quotient); end
      n_cmp++; if (remainder !== 15'd0) begin n_bad++; $display("FAIL reset_remainder got %h want 0", remainder); end
      n_cmp++; if ({out_valid, div_by_zero, ovf} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {out_valid, div_by_zero, ovf}); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_directed();
      logic [21:0] ta [4];
      logic [14:0] tb [4];
      logic        tsm [4];
      logic [35:0] teq [4];
      logic [14:0] ter [4];
      logic        tdbz [4];
      int          tlat [4];
      int          lat;
      ta   = '{22'd100, 22'd5, 22'd1, 22'h3FFF9C};
      tb   = '{15'd7, 15'd0, 15'd32767, 15'd7};
      tsm  = '{1'b0, 1'b0, 1'b0, 1'b1};
      teq  = '{36'd234057, 36'hFFFFFFFFF, 36'd0, 36'hFFFFC6DB7};
      ter  = '{15'd1, 15'd0, 15'd16384, 15'h7FFF};
      tdbz = '{1'b0, 1'b1, 1'b0, 1'b0};
      tlat = '{20, 1, 1, 20};
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dir%0d_in_ready got %b want 1", i, in_ready); end
         start_op(ta[i], tb[i], tsm[i]);
         n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy got %b want 0", i, in_ready); end
         wait_result(lat);
         n_cmp++; if (lat !== tlat[i]) begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, tlat[i]); end
         n_cmp++; if (quotient !== teq[i]) begin n_bad++; $display("FAIL dir%0d_quotient got %h want %h", i, quotient, teq[i]); end
         n_cmp++; if (remainder !== ter[i]) begin n_bad++; $display("FAIL dir%0d_remainder got %h want %h", i, remainder, ter[i]); end
         n_cmp++; if (div_by_zero !== tdbz[i] || ovf !== 1'b0) begin n_bad++; $display("FAIL dir%0d_flags got dbz=%b ovf=%b want dbz=%b ovf=0", i, div_by_zero, ovf, tdbz[i]); end
         consume();
      end
   endtask

   task automatic test_ovf_hold();
      int lat;
      start_op(22'h200000, 15'h7FFF, 1'b1);
      wait_result(lat);
      n_cmp++; if (lat !== 37) begin n_bad++; $display("FAIL ovf_latency got %0d want 37", lat); end
      n_cmp++; if (quotient !== 36'h7FFFFFFFF) begin n_bad++; $display("FAIL ovf_quotient got %h want 7ffffffff", quotient); end
      n_cmp++; if (remainder !== 15'd0) begin n_bad++; $display("FAIL ovf_remainder got %h want 0", remainder); end
      n_cmp++; if (ovf !== 1'b1 || div_by_zero !== 1'b0) begin n_bad++; $display("FAIL ovf_flags got ovf=%b dbz=%b want ovf=1 dbz=0", ovf, div_by_zero); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = (c % 2 == 0);
         dividend = 22'd123;
         divisor  = 15'd4;
         @(posedge clk);
         #1;
         n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL hold%0d_handshake got ov=%b ir=%b want ov=1 ir=0", c, out_valid, in_ready); end
         n_cmp++; if (quotient !== 36'h7FFFFFFFF || ovf !== 1'b1) begin n_bad++; $display("FAIL hold%0d_stable got q=%h ovf=%b want q=7ffffffff ovf=1", c, quotient, ovf); end
      end
      in_valid = 1'b0;
      consume();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL ignored_pulse got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
   endtask

   task automatic test_reset_mid_iter();
      int lat;
      int seen;
      start_op(22'd100, 15'd7, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_cmp++; if (quotient !== 36'd0 || remainder !== 15'd0) begin n_bad++; $display("FAIL midrst_outputs got q=%h r=%h want 0 0", quotient, remainder); end
      n_cmp++; if ({out_valid, div_by_zero, ovf} !== 3'b000) begin n_bad++; $display("FAIL midrst_flags got %b want 000", {out_valid, div_by_zero, ovf}); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
      seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_discard got %0d valid cycles want 0", seen); end
      start_op(22'd1, 15'd1, 1'b0);
      wait_result(lat);
      n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL after_rst_latency got %0d want 16", lat); end
      n_cmp++; if (quotient !== 36'd16384 || remainder !== 15'd0) begin n_bad++; $display("FAIL after_rst_result got q=%h r=%h want 4000 0", quotient, remainder); end
      consume();
   endtask

   task automatic test_random();
      logic [21:0] a;
      logic [14:0] b;
      logic        sm;
      logic [35:0] eq;
      logic [14:0] er;
      logic        edbz, eovf;
      int          elat, lat, k;
      for (int i = 0; i < 40; i++) begin
         k = int'($urandom_range(0, 9));
         case (k)
            0:       b = 15'd0;
            1, 2, 3: b = 15'($urandom_range(1, 15));
            4:       b = 15'h7FFF;
            default: b = 15'($urandom);
         endcase
         k = int'($urandom_range(0, 7));
         case (k)
            0:       a = 22'h200000;
            1:       a = 22'd0;
            default: a = 22'($urandom);
         endcase
         sm = 1'($urandom);
         model(a, b, sm, eq, er, edbz, eovf, elat);
         start_op(a, b, sm);
         wait_result(lat);
         n_cmp++; if (lat !== elat) begin n_bad++; $display("FAIL rnd%0d_latency a=%h b=%h sm=%b got %0d want %0d", i, a, b, sm, lat, elat); end
         n_cmp++; if (quotient !== eq) begin n_bad++; $display("FAIL rnd%0d_quotient a=%h b=%h sm=%b got %h want %h", i, a, b, sm, quotient, eq); end
         n_cmp++; if (remainder !== er) begin n_bad++; $display("FAIL rnd%0d_remainder a=%h b=%h sm=%b got %h want %h", i, a, b, sm, remainder, er); end
         n_cmp++; if (div_by_zero !== edbz || ovf !== eovf) begin n_bad++; $display("FAIL rnd%0d_flags got dbz=%b ovf=%b want dbz=%b ovf=%b", i, div_by_zero, ovf, edbz, eovf); end
         consume();
      end
   endtask

   task automatic test_back_to_back();
      logic [21:0] a;
      logic [14:0] b;
      logic        sm;
      logic [35:0] eq;
      logic [14:0] er;
      logic        edbz, eovf;
      int          elat, lat;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a  = 22'($urandom);
         b  = 15'($urandom_range(1, 32767));
         sm = 1'($urandom);
         model(a, b, sm, eq, er, edbz, eovf, elat);
         start_op(a, b, sm);
         wait_result(lat);
         n_cmp++; if (quotient !== eq || remainder !== er) begin n_bad++; $display("FAIL b2b%0d_result got q=%h r=%h want q=%h r=%h", i, quotient, remainder, eq, er); end
         @(posedge clk);
         #1;
         n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b%0d_return got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready); end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      rst         = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      dividend    = '0;
      divisor     = '0;
      signed_mode = 1'b0;
      test_reset();
      test_directed();
      test_ovf_hold();
      test_reset_mid_iter();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
